// File: rtl/gamma_pipe.sv
// Multi-channel two-stage gamma correction pipeline with run-time writable per-channel tables.
// Optional per-pixel bypass path is enabled by defining GAMMA_BYPASS_EN.
module gamma_pipe #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned IN_W     = 8,
  parameter int unsigned OUT_W    = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*IN_W-1:0]     in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*OUT_W-1:0]    out_data,
  input  logic                         wr_en,
  input  logic [$clog2(CHANNELS):0]    wr_chan,
  input  logic [IN_W-1:0]              wr_addr,
  input  logic [OUT_W-1:0]             wr_data,
  output logic                         busy
`ifdef GAMMA_BYPASS_EN
  ,
  input  logic                         bypass
`endif
);

  localparam int unsigned DEPTH   = 2**IN_W;
  localparam int unsigned LAST    = DEPTH - 1;
  localparam int unsigned MM      = LAST * LAST;
  localparam int unsigned OUT_MAX = 2**OUT_W - 1;
  localparam int unsigned PROD_W  = 2*IN_W + OUT_W + 1;

  typedef enum logic {INIT, RUN} state_e;

  state_e                      state_q, state_d;
  logic [IN_W-1:0]             cnt_q, cnt_d;
  logic                        busy_q, busy_d;

  logic                        s1_v_q, s1_v_d;
  logic [CHANNELS*IN_W-1:0]    s1_data_q, s1_data_d;
  logic                        s2_v_q, s2_v_d;
  logic [CHANNELS*OUT_W-1:0]   s2_data_q, s2_data_d;
`ifdef GAMMA_BYPASS_EN
  logic                        s1_byp_q, s1_byp_d;
`endif

  logic                        s1_load, s2_load;
  logic [CHANNELS-1:0]         tbl_we;
  logic [IN_W-1:0]             tbl_waddr;
  logic [OUT_W-1:0]            tbl_wdata;
  logic [OUT_W-1:0]            init_val;
  logic [OUT_W-1:0]            tbl_rd [CHANNELS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + IN_W'(1);
        if (cnt_q == IN_W'(LAST)) begin
          state_d = RUN;
          busy_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Rounded a^2 * OUT_MAX / M^2 at full precision; the divisor is constant.
  always_comb begin
    logic [PROD_W-1:0] sq;
    logic [PROD_W-1:0] num;
    sq       = PROD_W'(cnt_q) * PROD_W'(cnt_q);
    num      = sq * PROD_W'(OUT_MAX) + PROD_W'(MM / 2);
    init_val = OUT_W'(num / PROD_W'(MM));
  end

  always_comb begin
    int unsigned wc;
    wc        = 32'(wr_chan);
    tbl_we    = '0;
    tbl_waddr = cnt_q;
    tbl_wdata = init_val;
    if (state_q == INIT) begin
      tbl_we = '1;
    end else if (wr_en) begin
      tbl_waddr = wr_addr;
      tbl_wdata = wr_data;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        tbl_we[c] = (wc >= CHANNELS) || (wc == c);
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_tbl
    logic [OUT_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
      if (!reset && tbl_we[g]) begin
        mem_q[tbl_waddr] <= tbl_wdata;
      end
    end

    assign tbl_rd[g] = mem_q[s1_data_q[g*IN_W +: IN_W]];
  end

  assign s2_load  = !s2_v_q || out_ready;
  assign s1_load  = !s1_v_q || s2_load;
  assign in_ready = !reset && (state_q == RUN) && s1_load;

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
`ifdef GAMMA_BYPASS_EN
    s1_byp_d  = s1_byp_q;
`endif
    if (s1_load) begin
      s1_v_d = in_valid && in_ready;
      if (in_valid && in_ready) begin
        s1_data_d = in_data;
`ifdef GAMMA_BYPASS_EN
        s1_byp_d  = bypass;
`endif
      end
    end
    // S2 captures the table output at the edge, so a same-edge write is not seen.
    if (s2_load) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          s2_data_d[c*OUT_W +: OUT_W] = tbl_rd[c];
`ifdef GAMMA_BYPASS_EN
          if (s1_byp_q) begin
            s2_data_d[c*OUT_W +: OUT_W] =
              OUT_W'(s1_data_q[c*IN_W +: IN_W]) << (OUT_W - IN_W);
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      busy_q    <= 1'b1;
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
`ifdef GAMMA_BYPASS_EN
      s1_byp_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
`ifdef GAMMA_BYPASS_EN
      s1_byp_q  <= s1_byp_d;
`endif
    end
  end

  assign out_valid = s2_v_q;
  assign out_data  = s2_data_q;
  assign busy      = busy_q;

endmodule
